median_window_filter: RTL

//  Streaming sliding-window rank filter: keeps last TAPS samples, sorts a snapshot per new sample
//  by sequential odd-even transposition (one pass/clk), returns median, min or max plus full sorted

---
 rtl/median_window_filter_pkg.sv | 32 +++
 rtl/median_window_filter_if.sv | 27 ++
 rtl/median_window_filter_cmp_swap.sv | 17 +
 rtl/median_window_filter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/median_window_filter_pkg.sv
// Shared constants for the median window filter: FSM encodings, mode codes,
// the rank selection type and the legality rule for the window length.
package median_window_filter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] MODE_MED = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    typedef enum logic [1:0] {
        RANK_MED = 2'd0,
        RANK_MIN = 2'd1,
        RANK_MAX = 2'd2
    } rank_sel_e;

    function automatic bit taps_legal(input int taps);
        return (taps >= 3) && (taps <= 31) && ((taps % 2) == 1);
    endfunction

    // Mode 11 is treated as median so a stuck-high mode bus still yields a sane result.
    function automatic rank_sel_e decode_mode(input logic [1:0] mode);
        case (mode)
            MODE_MIN: return RANK_MIN;
            MODE_MAX: return RANK_MAX;
            default:  return RANK_MED;
        endcase
    endfunction

endpackage

// File: rtl/median_window_filter_if.sv
// Stream interface of the median window filter: sample input, result output,
// flush and status. master = source/consumer side, slave = filter side.
interface median_window_filter_if #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 9
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [1:0]              mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [TAPS*WIDTH-1:0]   sorted_out;
    logic                    busy;

    modport master (
        output flush, in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, sorted_out, busy
    );

    modport slave (
        input  flush, in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, sorted_out, busy
    );
endinterface

// File: rtl/median_window_filter_cmp_swap.sv
// Combinational compare-exchange cell: orders one adjacent pair of the sort vector.
module median_cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic swap;

    // Strict compare: equal values stay in place.
    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median_window_filter.sv
// Sliding-window rank filter: shifts in samples, sorts a snapshot of the full
// window with one odd-even transposition pass per clock, and holds the result.
//
// state   | meaning
// IDLE    | waiting for a sample; only state with in_ready high
// SORT    | TAPS compare-exchange passes, then one cycle to register the result
// HOLD    | out_valid high, result frozen until out_ready
module median_window_filter
    import median_window_filter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAPS  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    median_window_filter_if.slave  bus
);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int MID   = TAPS / 2;

    if (!taps_legal(TAPS)) begin : g_bad_taps
        $error("median_window_filter: TAPS must be odd and within 3..31");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] win    [TAPS];
    logic [WIDTH-1:0] sort_q [TAPS];
    logic [WIDTH-1:0] sort_d [TAPS];
    logic [WIDTH-1:0] cmp_lo [TAPS-1];
    logic [WIDTH-1:0] cmp_hi [TAPS-1];
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] pass_cnt;
    rank_sel_e        rank_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] rank_val;
    logic             accept;
    logic             full_after_accept;
    logic             passes_done;
    logic [TAPS*WIDTH-1:0] sorted_flat;

    assign bus.in_ready    = (state == ST_IDLE);
    assign accept          = bus.in_valid & bus.in_ready;
    assign full_after_accept = (fill_cnt >= CNT_W'(TAPS - 1));
    assign passes_done     = (pass_cnt == CNT_W'(TAPS));

    for (genvar i = 0; i < TAPS - 1; i++) begin : g_cmp
        median_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
            .a  (sort_q[i]),
            .b  (sort_q[i+1]),
            .lo (cmp_lo[i]),
            .hi (cmp_hi[i])
        );
    end

    // Pair i is live when its parity matches the pass parity; live pairs never overlap.
    always_comb begin
        for (int j = 0; j < TAPS; j++) begin
            sort_d[j] = sort_q[j];
        end
        for (int i = 0; i < TAPS - 1; i++) begin
            if (((i % 2) == 1) == pass_cnt[0]) begin
                sort_d[i]   = cmp_lo[i];
                sort_d[i+1] = cmp_hi[i];
            end
        end
    end

    always_comb begin
        case (rank_q)
            RANK_MIN: rank_val = sort_q[0];
            RANK_MAX: rank_val = sort_q[TAPS-1];
            default:  rank_val = sort_q[MID];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
            fill_cnt <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
            fill_cnt <= '0;
        end else if (accept) begin
            win[0] <= bus.in_data;
            for (int k = 1; k < TAPS; k++) begin
                win[k] <= win[k-1];
            end
            if (fill_cnt != CNT_W'(TAPS)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pass_cnt    <= '0;
            rank_q      <= RANK_MED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                sort_q[k] <= '0;
            end
        end else if (bus.flush) begin
            state       <= ST_IDLE;
            pass_cnt    <= '0;
            rank_q      <= RANK_MED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                sort_q[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // Snapshot is the window as it will look after this shift.
                    if (accept && full_after_accept) begin
                        sort_q[0] <= bus.in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            sort_q[k] <= win[k-1];
                        end
                        rank_q   <= decode_mode(bus.mode);
                        pass_cnt <= '0;
                        state    <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    if (passes_done) begin
                        out_data_q  <= rank_val;
                        out_valid_q <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        sort_q   <= sort_d;
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            sorted_flat[k*WIDTH +: WIDTH] = sort_q[k];
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.sorted_out = sorted_flat;
    assign bus.busy       = (state != ST_IDLE);

endmodule
